// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: CPU writeback has priority, a single
// buffered debug write is granted on an idle cycle or by a forced one-cycle stall.
module regfile_write_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_waddr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic [4:0]  dbg_waddr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic        dbg_pending,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2,
        ACK   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [AW-1:0]   hold_addr_q, hold_addr_d;
    logic [DW-1:0]   hold_data_q, hold_data_d;
    logic            cpu_stall_q, dbg_ack_q, dbg_pending_q;

    logic            sel_dbg;
    logic            src_we;
    logic [AW-1:0]   src_addr;

    // Next-state, holding buffer and wait counter
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        unique case (state_q)
            IDLE: begin
                if (dbg_req) begin
                    hold_addr_d = dbg_waddr;
                    hold_data_d = dbg_wdata;
                    wait_cnt_d  = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (!cpu_we) begin
                    state_d = ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE:   state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, buffer and Moore output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            hold_addr_q   <= '0;
            hold_data_q   <= '0;
            cpu_stall_q   <= 1'b0;
            dbg_ack_q     <= 1'b0;
            dbg_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            hold_addr_q   <= hold_addr_d;
            hold_data_q   <= hold_data_d;
            cpu_stall_q   <= (state_d == FORCE);
            dbg_ack_q     <= (state_d == ACK);
            dbg_pending_q <= (state_d == WAIT) || (state_d == FORCE);
        end
    end

    // Write-port mux; $0 writes suppressed, port held off during reset
    always_comb begin
        sel_dbg  = (state_q == FORCE) || ((state_q == WAIT) && !cpu_we);
        src_we   = sel_dbg ? 1'b1 : cpu_we;
        src_addr = sel_dbg ? hold_addr_q : cpu_waddr;
        rf_we    = src_we && (src_addr != '0) && reset;
        rf_waddr = (rf_we && sel_dbg) ? hold_addr_q : cpu_waddr;
        rf_wdata = (rf_we && sel_dbg) ? hold_data_q : cpu_wdata;
    end

    assign cpu_stall   = cpu_stall_q;
    assign dbg_ack     = dbg_ack_q;
    assign dbg_pending = dbg_pending_q;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the CPU writeback path and a debug/host requester (UART loader or board-level register poke). It sits directly in front of the register file write inputs. The CPU has priority; a debug request waits in a one-entry holding buffer and is granted on the first idle writeback cycle. After MAX_WAIT blocked cycles it forces a one-cycle CPU stall, so the debug request is never starved.

## Interface
- MAX_WAIT, 8, number of consecutive CPU-occupied cycles a pending debug write tolerates before forcing a stall; legal range 1..255
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- cpu_we  in  1  CPU writeback request (RegWrite)
- cpu_waddr  in  5  CPU destination register (rd/rt/$31, already selected)
- cpu_wdata  in  32  CPU writeback data
- cpu_stall  out  1  CPU must hold PC and pipeline state this cycle; its write is not performed
- dbg_req  in  1  debug write request, level, held until dbg_ack
- dbg_waddr  in  5  debug destination register, sampled when request is accepted
- dbg_wdata  in  32  debug write data, sampled when request is accepted
- dbg_ack  out  1  one-cycle pulse: debug write completed (or was discarded for $0)
- dbg_pending  out  1  a debug write is buffered and not yet performed
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data

## Operation
- States: IDLE, WAIT, FORCE, ACK. Holding registers hold_addr[4:0] and hold_data[31:0]. 8-bit wait_cnt.
- IDLE:
  - Port passes the CPU write through.
  - If dbg_req=1, latch dbg_waddr/dbg_wdata into the holding registers, clear wait_cnt, go to WAIT.
- WAIT (dbg_pending=1):
  - If cpu_we=0: drive the port from the holding registers, go to ACK.
  - If cpu_we=1: pass the CPU write through and increment wait_cnt.
  - If cpu_we=1 and wait_cnt==MAX_WAIT-1: go to FORCE.
- FORCE: cpu_stall=1 and dbg_pending=1. Drive the port from the holding registers and ignore cpu_we. Go to ACK.
- ACK:
  - dbg_ack=1 and the CPU write passes through.
  - dbg_req is ignored in this state. Go to IDLE.
- Requester rule: dbg_req drops on the edge ending the ACK cycle. Back-to-back requests need dbg_req low for at least one sampled IDLE cycle.
- Register $0 suppression: any write with address 0, from either source, gives rf_we=0. A debug write to $0 still completes the handshake and is acked.
- Same-address ordering: the later write wins. If the CPU writes register N while a debug write to N is pending, the debug write lands afterwards and overwrites it. No merging or cancellation.
- Port mux: rf_waddr/rf_wdata follow the selected source. When rf_we=0 they take the CPU values.

## Timing
- Reset values:
  - state=IDLE; wait_cnt, hold_addr and hold_data =0.
  - dbg_ack=0, dbg_pending=0, cpu_stall=0.
  - rf_we=0 while reset is asserted, regardless of cpu_we.
- cpu_stall, dbg_ack and dbg_pending are Moore outputs decoded from the state register; they have no combinational path from inputs.
- rf_* are combinational from the state, the holding registers and the cpu_* inputs. The register file commits on the next rising edge.
- Debug latency with the CPU idle: dbg_req sampled at edge 0 → write issued in cycle 1 (commits at edge 2) → dbg_ack high in cycle 2.
- Worst case: 1 + MAX_WAIT + 1 cycles from acceptance to the write cycle, plus 1 cycle to ack. Exactly one stall cycle per forced grant.
- wait_cnt saturates logically at MAX_WAIT-1 because FORCE exits WAIT; it never wraps.
- Reset asserted mid-operation (any state): the pending debug write is discarded with no rf_we and no dbg_ack. Return to IDLE asynchronously.

## Test plan
- Reset: hold reset=0 with cpu_we=1, dbg_req=1 → rf_we=0, dbg_ack=0, cpu_stall=0, dbg_pending=0. After release the state is IDLE.
- CPU passthrough: cpu_we=1, addr 5, data 0x00001234 → same-cycle rf_we=1, rf_waddr=5, rf_wdata=0x00001234. Addr 0 → rf_we=0.
- Debug with CPU idle: dbg_req addr 3, data 0xDEADBEEF sampled at edge 0, cpu_we=0 → cycle 1 rf_we=1 addr 3 data 0xDEADBEEF, cycle 2 dbg_ack=1, no stall.
- Starvation: MAX_WAIT=4, cpu_we=1 continuously, debug addr 7 → 4 CPU writes while dbg_pending=1, then one cycle with cpu_stall=1 and rf_waddr=7, then dbg_ack=1.
- Debug to $0 with data 0xFFFFFFFF → no rf_we=1 during the grant cycle, dbg_ack pulses once.
- Reset in WAIT after 2 blocked cycles → no debug write ever appears on rf_*, no dbg_ack. A new request after reset completes normally.
